// File: rtl/dram_burst_rd_ctrl.sv
// I-cache line-fill burst reader: one request becomes BLOCK_SIZE word reads on the
// memory port, and the words are returned in ascending order, one per dram_val pulse.
module dram_burst_rd_ctrl #(
  parameter int BLOCK_SIZE = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              dram_rd_req,
  input  logic [ADDR_W-1:0] dram_rd_addr,
  output logic              dram_val,
  output logic [31:0]       dram_rd_data,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(BLOCK_SIZE) + 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic             req_armed;

  logic issue_fire;
  logic ret_fire;
  logic last_issue;
  logic last_ret;

  // Returns are only taken while a burst is in flight and still short of a full line.
  always_comb begin
    issue_fire = (state == ISSUE) && mem_rd_en && mem_ready;
    ret_fire   = ((state == ISSUE) || (state == DRAIN)) && mem_rvalid && (ret_cnt < FULL);
    last_issue = issue_fire && (issue_cnt == LAST_IDX);
    last_ret   = ret_fire && (ret_cnt == LAST_IDX);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      req_armed    <= 1'b1;
      dram_val     <= 1'b0;
      dram_rd_data <= '0;
      busy         <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
    end else begin
      dram_val <= ret_fire;
      if (ret_fire) begin
        dram_rd_data <= mem_rdata;
        ret_cnt      <= ret_cnt + CNT_W'(1);
      end
      // A low request re-arms; a request held high across HOLD cannot retrigger.
      if (!dram_rd_req) begin
        req_armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (dram_rd_req && req_armed) begin
            state     <= ISSUE;
            req_armed <= 1'b0;
            busy      <= 1'b1;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= dram_rd_addr;
          end
        end
        ISSUE: begin
          if (issue_fire) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (last_issue) begin
              mem_rd_en <= 1'b0;
              state     <= ((ret_cnt + CNT_W'(ret_fire)) == FULL) ? HOLD : DRAIN;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (last_ret) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!dram_rd_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_rd_ctrl.sv
// Scoreboard bench for dram_burst_rd_ctrl with a latency-configurable in-order memory model.
module tb_dram_burst_rd_ctrl;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        dram_rd_req;
  logic [31:0] dram_rd_addr;
  logic        dram_val;
  logic [31:0] dram_rd_data;
  logic        busy;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  dram_burst_rd_ctrl #(.BLOCK_SIZE(8), .ADDR_W(32)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .dram_rd_req (dram_rd_req),
    .dram_rd_addr(dram_rd_addr),
    .dram_val    (dram_val),
    .dram_rd_data(dram_rd_data),
    .busy        (busy),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          lat = 2;
  int          rdy_mode = 0;
  bit          spur = 1'b0;
  logic [31:0] spur_data = 32'hDEAD_BEEF;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] pend_a[$];
  int          pend_due[$];
  int          issue_n = 0;
  int          first_iss = 0;
  int          last_iss = 0;
  int          vals_seen = 0;
  logic [31:0] last_data = '0;
  bit          ab;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: capture pre-edge handshakes, advance, score outputs, drive memory side.
  task automatic step();
    logic        iss;
    logic        stall;
    logic [31:0] ia;
    logic [31:0] ra;
    logic        deliver;
    iss   = mem_rd_en && mem_ready;
    stall = mem_rd_en && !mem_ready;
    ia    = mem_addr;
    @(posedge clock);
    #1;
    cyc++;
    if (iss) begin
      pend_a.push_back(ia);
      pend_due.push_back(cyc + lat - 1);
      if (exp_addr.size() == 0) begin
        check_eq("unexp_issue", iss, 0);
      end else begin
        check_eq("mem_addr", ia, exp_addr.pop_front());
      end
      if (issue_n == 0) first_iss = cyc;
      last_iss = cyc;
      issue_n++;
    end
    if (stall && rst_n) begin
      check_eq("stall_addr", mem_addr, ia);
      check_eq("stall_en", mem_rd_en, 1);
    end
    if (dram_val) begin
      vals_seen++;
      if (exp_data.size() == 0) begin
        check_eq("unexp_val", dram_val, 0);
      end else begin
        check_eq("rd_data", dram_rd_data, exp_data.pop_front());
      end
      last_data = dram_rd_data;
    end
    mem_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    deliver = rst_n && (pend_a.size() > 0) && (pend_due[0] <= cyc);
    if (deliver) begin
      ra = pend_a.pop_front();
      void'(pend_due.pop_front());
      mem_rvalid = 1'b1;
      mem_rdata  = ra << 2;
    end else begin
      mem_rvalid = spur;
      mem_rdata  = spur ? spur_data : 32'h0;
    end
  endtask

  task automatic run_burst(input logic [31:0] base, input int hold, input bit spur_hold,
                           input int abort_after, output bit aborted);
    logic [31:0] a;
    aborted = 1'b0;
    dram_rd_addr = base;
    dram_rd_req  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = base + 32'(i);
      exp_addr.push_back(a);
      exp_data.push_back(a << 2);
    end
    issue_n   = 0;
    vals_seen = 0;
    for (int n = 0; n < 300 && exp_data.size() > 0; n++) begin
      step();
      if (n == 0) dram_rd_addr = ~base;
      check_eq("busy", busy, 1);
      if (abort_after > 0 && vals_seen == abort_after) begin
        aborted = 1'b1;
        return;
      end
    end
    check_eq("vals_left", exp_data.size(), 0);
    check_eq("iss_left", exp_addr.size(), 0);
    if (spur_hold) begin
      spur       = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = spur_data;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      check_eq("hold_en", mem_rd_en, 0);
      check_eq("hold_busy", busy, 1);
      check_eq("hold_val", dram_val, 0);
      if (spur_hold) check_eq("hold_data", dram_rd_data, last_data);
    end
    spur        = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    dram_rd_req = 1'b0;
    step();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_en", mem_rd_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    dram_rd_req  = 1'b0;
    dram_rd_addr = '0;
    mem_ready    = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_val", dram_val, 0);
    check_eq("rst_data", dram_rd_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_en", mem_rd_en, 0);
    check_eq("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    step();
    step();

    // Basic burst
    lat = 2; rdy_mode = 0;
    run_burst(32'h0000_0100, 2, 1'b0, 0, ab);
    check_eq("consecutive", last_iss - first_iss, 7);

    // Backpressure
    lat = 3; rdy_mode = 1;
    run_burst(32'h0000_0180, 2, 1'b0, 0, ab);
    check_eq("bp_issues", issue_n, 8);

    // Re-arm: long hold, then a new request after one low cycle
    lat = 2; rdy_mode = 0;
    run_burst(32'h0000_0140, 5, 1'b0, 0, ab);
    run_burst(32'h0000_0200, 2, 1'b0, 0, ab);

    // Wrap-around
    run_burst(32'hFFFF_FFFC, 2, 1'b0, 0, ab);

    // Spurious returns in IDLE and HOLD
    spur       = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = spur_data;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("idle_val", dram_val, 0);
      check_eq("idle_data", dram_rd_data, last_data);
    end
    spur = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    lat = 1;
    run_burst(32'h0000_0700, 3, 1'b1, 0, ab);

    // Reset mid-burst with stale returns after release
    lat = 6;
    run_burst(32'h0000_0500, 0, 1'b0, 3, ab);
    check_eq("aborted", ab, 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_val", dram_val, 0);
    check_eq("mid_rst_data", dram_rd_data, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_en", mem_rd_en, 0);
    check_eq("mid_rst_addr", mem_addr, 0);
    exp_addr.delete();
    exp_data.delete();
    dram_rd_req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("stale_val", dram_val, 0);
      check_eq("stale_en", mem_rd_en, 0);
    end
    check_eq("stale_data", dram_rd_data, 0);
    check_eq("stale_drained", pend_a.size(), 0);
    lat = 2;
    run_burst(32'h0000_0600, 2, 1'b0, 0, ab);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
